// File: rtl/id_stage_if.sv
// id_stage_if: fetch-side handshake, flush, and the decoded bundle handed to execute.
//   slave  : decode-stage view (takes in_valid/inst/pc/flush/out_ready, drives the rest)
//   master : environment view (fetch + execute), directions mirrored
interface id_stage_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  logic              in_valid, in_ready;
  logic [31:0]       inst;
  logic [PC_W-1:0]   pc;
  logic              flush;
  logic              out_valid, out_ready;
  logic [3:0]        alu_ctr;
  logic              reg_wrt, mem_read, mem_wrt, mem_reg, alu_src;
  logic              branch, branch_ne, jump, link;
  logic [4:0]        rs, rt, dst;
  logic [DATA_W-1:0] imm_ext;
  logic [PC_W-1:0]   br_target, j_target, pc_plus4;
  logic              illegal;

  modport slave (
    input  in_valid, inst, pc, flush, out_ready,
    output in_ready, out_valid, alu_ctr, reg_wrt, mem_read, mem_wrt, mem_reg,
           alu_src, branch, branch_ne, jump, link, rs, rt, dst, imm_ext,
           br_target, j_target, pc_plus4, illegal
  );

  modport master (
    output in_valid, inst, pc, flush, out_ready,
    input  in_ready, out_valid, alu_ctr, reg_wrt, mem_read, mem_wrt, mem_reg,
           alu_src, branch, branch_ne, jump, link, rs, rt, dst, imm_ext,
           br_target, j_target, pc_plus4, illegal
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: registered MIPS decode stage with valid/ready flow control, flush,
// illegal-instruction flagging and a one-bubble load-use interlock.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : id_stage_if.slave -- in_valid/in_ready/inst/pc from fetch, flush,
//            out_valid/out_ready plus the decoded control/address/target bundle
module id_stage #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int HAZARD_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  id_stage_if.slave  bus
);
  localparam logic [5:0] OP_R    = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011,
                         OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000,
                         OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101,
                         OP_LUI  = 6'b001111, OP_LW   = 6'b100011, OP_SW   = 6'b101011;
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_LUI = 4'b1001;

  typedef struct packed {
    logic [3:0]        alu_ctr;
    logic              reg_wrt, mem_read, mem_wrt, mem_reg, alu_src;
    logic              branch, branch_ne, jump, link;
    logic [4:0]        rs, rt, dst;
    logic [DATA_W-1:0] imm_ext;
    logic [PC_W-1:0]   br_target, j_target, pc_plus4;
    logic              illegal;
  } dec_t;

  logic [5:0]  w_op, w_funct;
  logic [15:0] w_imm;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic        w_sext, w_zext, w_rd_rs, w_rd_rt;
  logic        w_adv, w_hazard, w_in_ready, w_cap;
  logic        w_unused_ok;
  dec_t        w_dec, r_dec;
  logic        r_vld, r_load_pend;
  logic [4:0]  r_load_rt;

  assign w_op    = bus.inst[31:26];
  assign w_rs    = bus.inst[25:21];
  assign w_rt    = bus.inst[20:16];
  assign w_rd    = bus.inst[15:11];
  assign w_funct = bus.inst[5:0];
  assign w_imm   = bus.inst[15:0];
  assign w_unused_ok = &{1'b0, bus.inst[10:6]};

  always_comb begin
    w_dec   = '0;
    w_sext  = 1'b0;
    w_zext  = 1'b0;
    // rs is read by everything but J/JAL/LUI; rt only by R-type, SW and branches
    w_rd_rs = !(w_op == OP_J || w_op == OP_JAL || w_op == OP_LUI);
    w_rd_rt = (w_op == OP_R || w_op == OP_SW || w_op == OP_BEQ || w_op == OP_BNE);
    w_dec.rs = w_rs;
    w_dec.rt = w_rt;
    case (w_op)
      OP_R: begin
        w_dec.reg_wrt = 1'b1;
        w_dec.dst     = w_rd;
        case (w_funct)
          6'b100000: w_dec.alu_ctr = ALU_ADD;
          6'b100010: w_dec.alu_ctr = ALU_SUB;
          6'b100100: w_dec.alu_ctr = ALU_AND;
          6'b100101: w_dec.alu_ctr = ALU_OR;
          6'b101010: w_dec.alu_ctr = ALU_SLT;
          default:   w_dec.illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        w_dec.alu_ctr = ALU_ADD; w_dec.alu_src = 1'b1; w_dec.mem_read = 1'b1;
        w_dec.mem_reg = 1'b1;    w_dec.reg_wrt = 1'b1; w_dec.dst = w_rt; w_sext = 1'b1;
      end
      OP_SW: begin
        w_dec.alu_ctr = ALU_ADD; w_dec.alu_src = 1'b1; w_dec.mem_wrt = 1'b1; w_sext = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        w_dec.alu_ctr   = ALU_SUB; w_dec.branch = 1'b1;
        w_dec.branch_ne = (w_op == OP_BNE); w_sext = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        w_dec.alu_src = 1'b1; w_dec.reg_wrt = 1'b1; w_dec.dst = w_rt;
        case (w_op)
          OP_ADDI: begin w_dec.alu_ctr = ALU_ADD; w_sext = 1'b1; end
          OP_SLTI: begin w_dec.alu_ctr = ALU_SLT; w_sext = 1'b1; end
          OP_ANDI: begin w_dec.alu_ctr = ALU_AND; w_zext = 1'b1; end
          OP_ORI:  begin w_dec.alu_ctr = ALU_OR;  w_zext = 1'b1; end
          default: begin w_dec.alu_ctr = ALU_LUI; w_zext = 1'b1; end
        endcase
      end
      OP_J:   w_dec.jump = 1'b1;
      OP_JAL: begin
        w_dec.jump = 1'b1; w_dec.link = 1'b1; w_dec.reg_wrt = 1'b1; w_dec.dst = 5'd31;
      end
      default: w_dec.illegal = 1'b1;
    endcase
    // Illegal instructions travel as a NOP: no side-effecting controls survive
    if (w_dec.illegal) begin
      w_dec.alu_ctr = '0; w_dec.reg_wrt = 1'b0; w_dec.dst = '0;
    end
    if (w_sext)      w_dec.imm_ext = {{(DATA_W-16){w_imm[15]}}, w_imm};
    else if (w_zext) w_dec.imm_ext = {{(DATA_W-16){1'b0}}, w_imm};
    w_dec.pc_plus4  = bus.pc + PC_W'(4);
    w_dec.br_target = w_dec.pc_plus4 + {{(PC_W-18){w_imm[15]}}, w_imm, 2'b00};
    // Mask form keeps this legal down to PC_W == 28 where no upper bits remain
    w_dec.j_target  = (w_dec.pc_plus4 & ~PC_W'(28'hFFF_FFFF)) |
                      PC_W'({bus.inst[25:0], 2'b00});
  end

  assign w_adv    = !r_vld || bus.out_ready;
  assign w_hazard = (HAZARD_EN != 0) && bus.in_valid && r_load_pend && (r_load_rt != 5'd0) &&
                    ((w_rd_rs && w_rs == r_load_rt) || (w_rd_rt && w_rt == r_load_rt));
  assign w_in_ready = w_adv && !w_hazard && !bus.flush;
  assign w_cap      = bus.in_valid && w_in_ready;

  // The hazard cycle falls into the adv-without-capture branch: the bubble it
  // emits also clears load_pend, so the dependent instruction is taken next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld       <= 1'b0;
      r_load_pend <= 1'b0;
      r_load_rt   <= '0;
      r_dec       <= '0;
    end else if (bus.flush) begin
      r_vld       <= 1'b0;
      r_load_pend <= 1'b0;
    end else if (w_cap) begin
      r_dec       <= w_dec;
      r_vld       <= 1'b1;
      r_load_pend <= (w_op == OP_LW);
      r_load_rt   <= w_rt;
    end else if (w_adv) begin
      r_vld       <= 1'b0;
      r_load_pend <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld;
  assign bus.alu_ctr   = r_dec.alu_ctr;
  assign bus.reg_wrt   = r_dec.reg_wrt;
  assign bus.mem_read  = r_dec.mem_read;
  assign bus.mem_wrt   = r_dec.mem_wrt;
  assign bus.mem_reg   = r_dec.mem_reg;
  assign bus.alu_src   = r_dec.alu_src;
  assign bus.branch    = r_dec.branch;
  assign bus.branch_ne = r_dec.branch_ne;
  assign bus.jump      = r_dec.jump;
  assign bus.link      = r_dec.link;
  assign bus.rs        = r_dec.rs;
  assign bus.rt        = r_dec.rt;
  assign bus.dst       = r_dec.dst;
  assign bus.imm_ext   = r_dec.imm_ext;
  assign bus.br_target = r_dec.br_target;
  assign bus.j_target  = r_dec.j_target;
  assign bus.pc_plus4  = r_dec.pc_plus4;
  assign bus.illegal   = r_dec.illegal;
endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  id_stage_if #(.DATA_W(32), .PC_W(32)) bus  ();
  id_stage_if #(.DATA_W(32), .PC_W(32)) bus0 ();
  id_stage #(.DATA_W(32), .PC_W(32), .HAZARD_EN(1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  id_stage #(.DATA_W(32), .PC_W(32), .HAZARD_EN(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  typedef struct packed {
    logic [3:0]  alu;
    logic        rw, mr, mw, mreg, asrc, br, bne, j, lk;
    logic [4:0]  rs, rt, dst;
    logic [31:0] imm, bt, jt, p4;
    logic        ill;
  } exp_t;

  int   errs = 0, checks = 0;
  exp_t q[$];
  bit   mon_en = 0;
  // bench-side view of the stage state
  bit         m_valid = 0, m_lp = 0;
  logic [4:0] m_lrt = '0;

  function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] p);
    exp_t e = '0;
    logic [5:0]  op = i[31:26];
    logic [5:0]  fn = i[5:0];
    logic [31:0] sx = {{16{i[15]}}, i[15:0]};
    logic [31:0] zx = {16'h0, i[15:0]};
    e.rs = i[25:21]; e.rt = i[20:16];
    e.p4 = p + 32'd4;
    e.bt = e.p4 + sx * 4;
    e.jt = (e.p4 & 32'hF000_0000) | ({6'd0, i[25:0]} * 4);
    case (op)
      6'd0: begin
        case (fn)
          6'd32: e.alu = 4'd2;  6'd34: e.alu = 4'd6; 6'd36: e.alu = 4'd0;
          6'd37: e.alu = 4'd1;  6'd42: e.alu = 4'd7;
          default: e.ill = 1;
        endcase
        if (!e.ill) begin e.rw = 1; e.dst = i[15:11]; end
      end
      6'd35: begin e.alu = 2; e.asrc = 1; e.mr = 1; e.mreg = 1; e.rw = 1; e.dst = i[20:16]; e.imm = sx; end
      6'd43: begin e.alu = 2; e.asrc = 1; e.mw = 1; e.imm = sx; end
      6'd4:  begin e.alu = 6; e.br = 1; e.imm = sx; end
      6'd5:  begin e.alu = 6; e.br = 1; e.bne = 1; e.imm = sx; end
      6'd8:  begin e.alu = 2; e.asrc = 1; e.rw = 1; e.dst = i[20:16]; e.imm = sx; end
      6'd10: begin e.alu = 7; e.asrc = 1; e.rw = 1; e.dst = i[20:16]; e.imm = sx; end
      6'd12: begin e.alu = 0; e.asrc = 1; e.rw = 1; e.dst = i[20:16]; e.imm = zx; end
      6'd13: begin e.alu = 1; e.asrc = 1; e.rw = 1; e.dst = i[20:16]; e.imm = zx; end
      6'd15: begin e.alu = 9; e.asrc = 1; e.rw = 1; e.dst = i[20:16]; e.imm = zx; end
      6'd2:  e.j = 1;
      6'd3:  begin e.j = 1; e.lk = 1; e.rw = 1; e.dst = 5'd31; end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  function automatic bit uses_reg(input logic [31:0] i, input logic [4:0] r);
    logic [5:0] op = i[31:26];
    bit rd_rs = !(op == 6'd2 || op == 6'd3 || op == 6'd15);
    bit rd_rt = (op == 6'd0 || op == 6'd43 || op == 6'd4 || op == 6'd5);
    return (rd_rs && i[25:21] == r) || (rd_rt && i[20:16] == r);
  endfunction

  function automatic exp_t grab();
    return {bus.alu_ctr, bus.reg_wrt, bus.mem_read, bus.mem_wrt, bus.mem_reg, bus.alu_src,
            bus.branch, bus.branch_ne, bus.jump, bus.link, bus.rs, bus.rt, bus.dst,
            bus.imm_ext, bus.br_target, bus.j_target, bus.pc_plus4, bus.illegal};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the presented output with the scoreboard head; retire it
  // when execute takes it or a flush kills it.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      chk("out_valid", bus.out_valid, q.size() != 0);
      if (bus.out_valid && q.size() != 0) begin
        chk("decoded", grab(), q[0]);
        if (bus.out_ready || bus.flush) void'(q.pop_front());
      end
    end
  end

  // One cycle of stimulus, entered and left at a negedge.
  task automatic cycle(input bit v, input logic [31:0] i, input logic [31:0] p,
                       input bit ordy, input bit fl, output bit acc);
    bit adv, hz, rdy;
    bus.in_valid = v; bus.inst = i; bus.pc = p; bus.out_ready = ordy; bus.flush = fl;
    adv = !m_valid || ordy;
    hz  = v && m_lp && m_lrt != 0 && uses_reg(i, m_lrt);
    rdy = adv && !hz && !fl;
    #1 chk("in_ready", bus.in_ready, rdy);
    acc = v && rdy;
    @(posedge clk);
    if (fl) begin m_valid = 0; m_lp = 0; end
    else if (acc) begin
      q.push_back(ref_dec(i, p));
      m_valid = 1; m_lp = (i[31:26] == 6'd35); m_lrt = i[20:16];
    end else if (adv) begin m_valid = 0; m_lp = 0; end
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p, output int tries);
    bit acc = 0;
    tries = 0;
    while (!acc && tries < 20) begin
      cycle(1, i, p, 1, 0, acc);
      tries++;
    end
    if (!acc) begin errs++; checks++; $display("FAIL send_timeout: inst %08h never accepted", i); end
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [5:0] ops [14] = '{0, 0, 35, 43, 4, 5, 8, 10, 12, 13, 15, 2, 3, 63};
    logic [5:0] fns [6]  = '{32, 34, 36, 37, 42, 7};
    logic [5:0] op = ops[$urandom_range(13)];
    if (op == 2 || op == 3) return {op, 26'($urandom)};
    return {op, 5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(7)),
            5'($urandom), fns[$urandom_range(5)]} | (op == 0 ? 32'd0 : {16'd0, 16'($urandom)});
  endfunction

  initial begin
    int t;
    bit acc;
    bus.in_valid = 0; bus.inst = 0; bus.pc = 0; bus.out_ready = 0; bus.flush = 0;
    bus0.in_valid = 0; bus0.inst = 0; bus0.pc = 0; bus0.out_ready = 1; bus0.flush = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_outputs", grab(), 0);
    chk("reset_in_ready", bus.in_ready, 1);
    @(negedge clk);
    mon_en = 1;

    send(32'h0022_1820, 32'h0000_1000, t);              // ADD $3,$1,$2
    send(32'h8C22_0004, 32'h0000_1004, t);              // LW $2,4($1)
    send(32'h0041_1820, 32'h0000_1008, t);              // ADD $3,$2,$1: one stall
    chk("loaduse_stall_cycles", t, 2);
    send(32'h3405_FFFF, 32'h0000_100C, t);              // ORI
    send(32'h2005_FFFF, 32'h0000_1010, t);              // ADDI -1
    send(32'h0C10_0004, 32'h0040_0000, t);              // JAL
    send(32'hFC00_0000, 32'h0000_1018, t);              // illegal opcode
    send(32'h0000_0007, 32'h0000_101C, t);              // illegal funct
    send(32'h8C22_0004, 32'h0000_1020, t);              // LW $2 then back-pressure + flush
    cycle(1, 32'h0041_1820, 32'h0000_1024, 0, 0, acc);
    cycle(1, 32'h0041_1820, 32'h0000_1024, 0, 1, acc);
    cycle(1, 32'h0041_1820, 32'h0000_1024, 0, 0, acc);
    chk("post_flush_no_hazard", acc, 1);
    cycle(0, 0, 0, 1, 0, acc);

    for (int n = 0; n < 600; n++)
      cycle($urandom_range(3) != 0, rnd_inst(), {$urandom} & 32'hFFFF_FFFC,
            $urandom_range(3) != 0, $urandom_range(31) == 0, acc);

    // asynchronous reset while an instruction sits in the output register
    cycle(0, 0, 0, 1, 0, acc);
    send(32'h0022_1820, 32'h0000_2000, t);
    mon_en = 0;
    bus.out_ready = 0;
    #1 chk("pre_reset_valid", bus.out_valid, 1);
    #1 rst_n = 0;
    #1;
    chk("async_reset_valid", bus.out_valid, 0);
    chk("async_reset_outputs", grab(), 0);
    q.delete(); m_valid = 0; m_lp = 0;
    @(negedge clk);
    rst_n = 1;

    // HAZARD_EN=0: LW then dependent ADD flow back-to-back
    @(negedge clk);
    bus0.in_valid = 1; bus0.inst = 32'h8C22_0004; bus0.pc = 32'h100;
    #1 chk("nohz_ready_lw", bus0.in_ready, 1);
    @(negedge clk);
    bus0.inst = 32'h0041_1820;
    #1 chk("nohz_ready_add", bus0.in_ready, 1);
    chk("nohz_lw_out", {bus0.out_valid, bus0.mem_read, bus0.dst}, {1'b1, 1'b1, 5'd2});
    @(negedge clk);
    bus0.in_valid = 0;
    #1 chk("nohz_add_out", {bus0.out_valid, bus0.mem_read, bus0.dst}, {1'b1, 1'b0, 5'd3});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/id_stage.md
# id_stage

Registered, handshaked MIPS instruction-decode pipeline stage. It decodes one instruction per accepted beat into datapath control, register addresses, an extended immediate and branch/jump targets, and holds them in an output register for the execute stage. It extends the base decoder with more opcodes, illegal-instruction flagging, valid/ready flow control, flush, and an internal load-use interlock that inserts a one-cycle bubble.

## Interface
- DATA_W, 32: immediate extension width (≥32).
- PC_W, 32: program-counter width (≥28).
- HAZARD_EN, 1: 1 = load-use interlock active; 0 = never stall.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents inst/pc.
- in_ready  out  1  stage accepts this cycle (combinational).
- inst  in  32  instruction word.
- pc  in  PC_W  address of inst.
- flush  in  1  synchronous kill of output register and interlock state.
- out_valid  out  1  output register holds a decoded instruction.
- out_ready  in  1  execute consumes this cycle.
- alu_ctr  out  4  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, LUI 1001.
- reg_wrt, mem_read, mem_wrt, mem_reg, alu_src, branch, branch_ne, jump, link  out  1 each  control.
- rs, rt, dst  out  5 each  source and write-destination register numbers.
- imm_ext  out  DATA_W  extended immediate.
- br_target, j_target, pc_plus4  out  PC_W each  targets / link value.
- illegal  out  1  unsupported opcode or funct.

## Operation
- Fields: op=inst[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0], addr=[25:0].
- R-type (op 0): funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; reg_wrt=1, dst=rd.
- LW 100011: ADD, alu_src, mem_read, mem_reg, reg_wrt, dst=rt. SW 101011: ADD, alu_src, mem_wrt (mem_reg=0, reg_wrt=0).
- BEQ 000100 / BNE 000101: SUB, branch=1, branch_ne=0/1.
- ADDI 001000 ADD, SLTI 001010 SLT, ANDI 001100 AND, ORI 001101 OR, LUI 001111 LUI: alu_src, reg_wrt, dst=rt.
- J 000010: jump. JAL 000011: jump, link, reg_wrt, dst=31.
- Sign-extend imm for LW, SW, BEQ, BNE, ADDI, SLTI; zero-extend for ANDI, ORI, LUI; others 0.
- pc_plus4=pc+4 (mod 2^PC_W); br_target=pc_plus4+(sext(imm)<<2); j_target={pc_plus4[PC_W-1:28], addr, 2'b00}.
- Unknown op or R-type funct: illegal=1, all write/memory/branch/jump controls 0, alu_ctr=0000; the instruction still flows as a NOP.
- Reads: rs by all except J, JAL, LUI; rt by R-type, SW, BEQ, BNE.
- Interlock state: load_pend, load_rt. adv = !out_valid || out_ready.
- hazard = HAZARD_EN && in_valid && load_pend && load_rt!=0 && (load_rt==rs read || load_rt==rt read).
- in_ready = adv && !hazard && !flush. capture = in_valid && in_ready.

## Timing
- Reset: out_valid=0, load_pend=0, every decoded output 0; in_ready=1 once rst_n=1 and flush=0.
- Latency: 1 cycle; data captured on edge with capture=1 is on outputs the next cycle. Throughput 1/cycle.
- Edge priority: flush > capture > advance-without-capture > hold.
- flush: out_valid←0, load_pend←0; input not accepted.
- capture: output register loaded, out_valid←1, load_pend←(instruction is LW), load_rt←rt.
- adv without capture (includes hazard cycle): out_valid←0, load_pend←0, emitting the single bubble.
- !adv: all registers hold; outputs stable while out_valid && !out_ready.
- Hazard stalls exactly one bubble; when execute back-pressure already created a gap, no extra bubble.
- rst_n low mid-transfer: immediate clear regardless of clk; in-flight instruction lost.

## Test plan
- Reset, then ADD $3,$1,$2 (0x00221820) → next cycle out_valid=1, alu_ctr=0010, reg_wrt=1, dst=3, illegal=0.
- LW $2,4($1) (0x8C220004) then ADD $3,$2,$1 (0x00411820) back-to-back, out_ready=1 → in_ready=0 one cycle, one out_valid=0 cycle, then the ADD; repeat with HAZARD_EN=0 → no bubble.
- ORI $5,$0,0xFFFF (0x3405FFFF) → imm_ext=0x0000FFFF; ADDI $5,$0,-1 (0x2005FFFF) → imm_ext=0xFFFFFFFF, alu_ctr=0010.
- JAL at pc=0x00400000, inst 0x0C100004 → j_target=0x00400010, dst=31, link=1, pc_plus4=0x00400004.
- out_ready=0 for 3 cycles with in_valid=1 → outputs stable, in_ready=0; flush in cycle 2 → out_valid=0 next cycle, load_pend cleared.
- Opcode 111111 and R-type funct 000111 → illegal=1, reg_wrt=mem_wrt=branch=jump=0; assert rst_n low mid-stream → out_valid drops before next edge.
